// File: rtl/logger_ev_packer_mc_if.sv
// Event-port and byte-stream bundle for the multi-channel event packer.
// The packer connects through "master"; the event sources and byte sink connect through "slave".
interface logger_ev_packer_mc_if #(
  parameter int N_CH = 4,
  parameter int ID_W = 16,
  parameter int TS_W = 64
);
  logic [N_CH-1:0]      ev_valid;
  logic [N_CH-1:0]      ev_ready;
  logic [N_CH*ID_W-1:0] ev_id;
  logic [N_CH*TS_W-1:0] ev_start;
  logic [N_CH*TS_W-1:0] ev_end;
  logic [N_CH*TS_W-1:0] ev_delta;
  logic [2:0]           fields_sel;
  logic                 byte_valid;
  logic                 byte_ready;
  logic [7:0]           byte_data;
  logic                 byte_last;

  modport master (
    input  ev_valid, ev_id, ev_start, ev_end, ev_delta, fields_sel, byte_ready,
    output ev_ready, byte_valid, byte_data, byte_last
  );

  modport slave (
    output ev_valid, ev_id, ev_start, ev_end, ev_delta, fields_sel, byte_ready,
    input  ev_ready, byte_valid, byte_data, byte_last
  );
endinterface

// File: rtl/logger_ev_packer_mc.sv
// Round-robin arbiter over N_CH event ports that turns each accepted event into an ASCII hex line
// "[ch,]id[,start][,end][,delta]\n" on a valid/ready byte stream.
module logger_ev_packer_mc #(
  parameter int N_CH    = 4,
  parameter int ID_W    = 16,
  parameter int TS_W    = 64,
  parameter int EMIT_CH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  logger_ev_packer_mc_if.master bus,
  output logic [31:0]           lines_sent
);

  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CHP_W   = CH_W + 1;
  localparam int CH_NIB  = (N_CH > 1) ? ($clog2(N_CH) + 3) / 4 : 1;
  localparam int ID_NIB  = (ID_W + 3) / 4;
  localparam int TS_NIB  = (TS_W + 3) / 4;
  localparam int MAX_A   = (ID_NIB > TS_NIB) ? ID_NIB : TS_NIB;
  localparam int MAX_NIB = (CH_NIB > MAX_A) ? CH_NIB : MAX_A;
  localparam int VAL_W   = MAX_NIB * 4;
  localparam int NIB_W   = $clog2(MAX_NIB + 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;
  typedef enum logic [2:0] {
    F_CH    = 3'd0,
    F_ID    = 3'd1,
    F_START = 3'd2,
    F_END   = 3'd3,
    F_DELTA = 3'd4,
    F_NL    = 3'd5
  } field_t;

  localparam field_t FIRST_F = (EMIT_CH != 0) ? F_CH : F_ID;

  state_t            state_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   ch_q;
  logic [VAL_W-1:0]  id_q;
  logic [VAL_W-1:0]  start_q;
  logic [VAL_W-1:0]  end_q;
  logic [VAL_W-1:0]  delta_q;
  logic [2:0]        sel_q;
  field_t            field_q;
  logic [NIB_W-1:0]  nib_q;
  logic              comma_q;
  logic              byte_valid_q;
  logic [7:0]        byte_data_q;
  logic              byte_last_q;
  logic [31:0]       lines_q;

  logic [CH_W-1:0]   grant_s;
  logic              any_valid_s;
  logic              accept_s;
  logic [N_CH-1:0]   ev_ready_s;
  field_t            nxt_field_s;
  logic [NIB_W-1:0]  nxt_nib_s;
  logic              nxt_comma_s;
  logic [VAL_W-1:0]  nxt_val_s;
  logic [VAL_W-1:0]  first_val_s;
  logic [7:0]        adv_byte_s;
  logic [7:0]        first_byte_s;

  logic [ID_W-1:0]   ev_id_a    [N_CH];
  logic [TS_W-1:0]   ev_start_a [N_CH];
  logic [TS_W-1:0]   ev_end_a   [N_CH];
  logic [TS_W-1:0]   ev_delta_a [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_unpack
    assign ev_id_a[c]    = bus.ev_id[c*ID_W +: ID_W];
    assign ev_start_a[c] = bus.ev_start[c*TS_W +: TS_W];
    assign ev_end_a[c]   = bus.ev_end[c*TS_W +: TS_W];
    assign ev_delta_a[c] = bus.ev_delta[c*TS_W +: TS_W];
  end

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] r;
    if (nib < 4'd10) r = 8'h30 + {4'h0, nib};
    else             r = 8'h37 + {4'h0, nib};
    return r;
  endfunction

  function automatic logic [NIB_W-1:0] fld_ndig(input field_t f);
    logic [NIB_W-1:0] n;
    case (f)
      F_CH:                     n = NIB_W'(CH_NIB);
      F_ID:                     n = NIB_W'(ID_NIB);
      F_START, F_END, F_DELTA:  n = NIB_W'(TS_NIB);
      default:                  n = NIB_W'(1);
    endcase
    return n;
  endfunction

  // Mandatory id follows the channel; optional fields are skipped according to the captured select.
  function automatic field_t next_field(input field_t f, input logic [2:0] sel);
    field_t nf;
    case (f)
      F_CH:    nf = F_ID;
      F_ID:    nf = sel[0] ? F_START : (sel[1] ? F_END : (sel[2] ? F_DELTA : F_NL));
      F_START: nf = sel[1] ? F_END : (sel[2] ? F_DELTA : F_NL);
      F_END:   nf = sel[2] ? F_DELTA : F_NL;
      default: nf = F_NL;
    endcase
    return nf;
  endfunction

  function automatic logic [7:0] pos_byte(input field_t f, input logic [NIB_W-1:0] nib,
                                          input logic comma, input logic [VAL_W-1:0] val);
    logic [NIB_W-1:0] idx;
    logic [VAL_W-1:0] sh;
    logic [7:0]       r;
    idx = fld_ndig(f) - nib - NIB_W'(1);
    sh  = val >> {idx, 2'b00};
    if (comma)          r = 8'h2C;
    else if (f == F_NL) r = 8'h0A;
    else                r = hex_ascii(sh[3:0]);
    return r;
  endfunction

  // Round-robin grant: lowest offset from rr_ptr_q wins, so scan offsets from high to low.
  always_comb begin
    logic [CHP_W-1:0] sum_v;
    grant_s     = '0;
    any_valid_s = 1'b0;
    sum_v       = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      sum_v = {1'b0, rr_ptr_q} + CHP_W'(i);
      if (sum_v >= CHP_W'(N_CH)) sum_v = sum_v - CHP_W'(N_CH);
      else                       sum_v = sum_v;
      if (bus.ev_valid[sum_v[CH_W-1:0]]) begin
        grant_s     = sum_v[CH_W-1:0];
        any_valid_s = 1'b1;
      end else begin
        any_valid_s = any_valid_s;
      end
    end
  end

  // One-hot ready toward the granted channel, only while idle.
  always_comb begin
    ev_ready_s = '0;
    accept_s   = (state_q == S_IDLE) && any_valid_s;
    if (accept_s) ev_ready_s[grant_s] = 1'b1;
    else          ev_ready_s = '0;
  end

  // Position of the byte after the current one, and its character.
  always_comb begin
    nxt_field_s = field_q;
    nxt_nib_s   = nib_q;
    nxt_comma_s = 1'b0;
    if (comma_q) begin
      nxt_nib_s = '0;
    end else if (nib_q == fld_ndig(field_q) - NIB_W'(1)) begin
      nxt_field_s = next_field(field_q, sel_q);
      nxt_nib_s   = '0;
      nxt_comma_s = (nxt_field_s != F_NL);
    end else begin
      nxt_nib_s = nib_q + NIB_W'(1);
    end
    case (nxt_field_s)
      F_CH:    nxt_val_s = VAL_W'(ch_q);
      F_ID:    nxt_val_s = id_q;
      F_START: nxt_val_s = start_q;
      F_END:   nxt_val_s = end_q;
      F_DELTA: nxt_val_s = delta_q;
      default: nxt_val_s = '0;
    endcase
    adv_byte_s = pos_byte(nxt_field_s, nxt_nib_s, nxt_comma_s, nxt_val_s);
  end

  // First character is taken straight from the inputs so it can be registered on the accept edge.
  always_comb begin
    if (EMIT_CH != 0) first_val_s = VAL_W'(grant_s);
    else              first_val_s = VAL_W'(ev_id_a[grant_s]);
    first_byte_s = pos_byte(FIRST_F, '0, 1'b0, first_val_s);
  end

  // Arbitration, capture and byte sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      ch_q         <= '0;
      id_q         <= '0;
      start_q      <= '0;
      end_q        <= '0;
      delta_q      <= '0;
      sel_q        <= 3'b000;
      field_q      <= FIRST_F;
      nib_q        <= '0;
      comma_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_last_q  <= 1'b0;
      lines_q      <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            ch_q         <= grant_s;
            id_q         <= VAL_W'(ev_id_a[grant_s]);
            start_q      <= VAL_W'(ev_start_a[grant_s]);
            end_q        <= VAL_W'(ev_end_a[grant_s]);
            delta_q      <= VAL_W'(ev_delta_a[grant_s]);
            sel_q        <= bus.fields_sel;
            rr_ptr_q     <= (grant_s == CH_W'(N_CH - 1)) ? '0 : grant_s + CH_W'(1);
            field_q      <= FIRST_F;
            nib_q        <= '0;
            comma_q      <= 1'b0;
            byte_valid_q <= 1'b1;
            byte_data_q  <= first_byte_s;
            byte_last_q  <= 1'b0;
            state_q      <= S_SEND;
          end else begin
            byte_valid_q <= 1'b0;
          end
        end
        S_SEND: begin
          if (bus.byte_ready) begin
            if (field_q == F_NL) begin
              lines_q      <= lines_q + 32'd1;
              byte_valid_q <= 1'b0;
              byte_data_q  <= 8'h00;
              byte_last_q  <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              field_q      <= nxt_field_s;
              nib_q        <= nxt_nib_s;
              comma_q      <= nxt_comma_s;
              byte_data_q  <= adv_byte_s;
              byte_last_q  <= (nxt_field_s == F_NL);
            end
          end else begin
            byte_valid_q <= byte_valid_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ev_ready   = ev_ready_s;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.byte_last  = byte_last_q;
  assign lines_sent     = lines_q;

endmodule

// File: tb/tb_logger_ev_packer_mc.sv
// Directed bench for logger_ev_packer_mc: hand-written lines plus a line-text and round-robin model.
module tb_logger_ev_packer_mc;

  logic        clk;
  logic        rst;
  logic [31:0] lines_sent;

  logger_ev_packer_mc_if #(.N_CH(4), .ID_W(16), .TS_W(64)) ifc ();

  logger_ev_packer_mc #(.N_CH(4), .ID_W(16), .TS_W(64), .EMIT_CH(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifc),
    .lines_sent (lines_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [3:0]  val_m;
  logic [2:0]  sel_m;
  logic [15:0] id_m [4];
  logic [63:0] st_m [4];
  logic [63:0] en_m [4];
  logic [63:0] de_m [4];
  int          rr_m;
  logic [31:0] lines_exp;
  string       exp_q [$];
  string       last_line;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chks(input string tag, input string obs, input string exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s: observed len %0d [%s] expected len %0d [%s]", tag, obs.len(), obs, exp.len(), exp);
    end
  endtask

  function automatic string hexs(input logic [63:0] v, input int n);
    string s;
    s = "";
    for (int i = n - 1; i >= 0; i--) s = {s, $sformatf("%h", v[4*i +: 4])};
    return s.toupper();
  endfunction

  function automatic string fmt_line(input int g);
    string s;
    s = {hexs(64'(g), 1), ",", hexs(64'(id_m[g]), 4)};
    if (sel_m[0]) s = {s, ",", hexs(st_m[g], 16)};
    if (sel_m[1]) s = {s, ",", hexs(en_m[g], 16)};
    if (sel_m[2]) s = {s, ",", hexs(de_m[g], 16)};
    return {s, "\n"};
  endfunction

  function automatic int model_grant();
    int c;
    for (int i = 0; i < 4; i++) begin
      c = (rr_m + i) % 4;
      if (val_m[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive();
    ifc.ev_valid   = val_m;
    ifc.fields_sel = sel_m;
    for (int c = 0; c < 4; c++) begin
      ifc.ev_id[c*16 +: 16]    = id_m[c];
      ifc.ev_start[c*64 +: 64] = st_m[c];
      ifc.ev_end[c*64 +: 64]   = en_m[c];
      ifc.ev_delta[c*64 +: 64] = de_m[c];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    val_m = 4'b0000;
    sel_m = 3'b000;
    drive();
    ifc.byte_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rr_m = 0;
    lines_exp = 32'd0;
    exp_q.delete();
    #1;
    chk("rst_ev_ready", 64'(ifc.ev_ready), 64'd0);
    chk("rst_byte_valid", 64'(ifc.byte_valid), 64'd0);
    chk("rst_byte_data", 64'(ifc.byte_data), 64'd0);
    chk("rst_byte_last", 64'(ifc.byte_last), 64'd0);
    chk("rst_lines_sent", 64'(lines_sent), 64'd0);
  endtask

  // mode 0: drop valid after accept; 1: hold valid and data; 2: hold valid, new random event
  task automatic run(input int nlines, input bit rnd, input int mode, input int gap_exp);
    int done, gap, budget, acc_ch, g;
    bit armed, acc_prev, stall_prev;
    logic [7:0] pd;
    logic pl;
    string cur;
    done = 0; gap = 0; armed = 1'b0; acc_prev = 1'b0; stall_prev = 1'b0;
    pd = 8'h00; pl = 1'b0; cur = ""; budget = nlines * 150 + 100;
    for (int cyc = 0; cyc < budget && done < nlines; cyc++) begin
      drive();
      ifc.byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (acc_prev) chk("first_byte_latency", 64'(ifc.byte_valid), 64'd1);
      if (stall_prev) begin
        chk("hold_data", 64'(ifc.byte_data), 64'(pd));
        chk("hold_last", 64'(ifc.byte_last), 64'(pl));
      end
      acc_ch = -1;
      if (ifc.ev_ready != 4'b0000) begin
        g = model_grant();
        chk("grant_onehot", 64'(ifc.ev_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (g >= 0) begin
          exp_q.push_back(fmt_line(g));
          rr_m = (g + 1) % 4;
          acc_ch = g;
        end
      end
      if (ifc.byte_valid) begin
        if (armed && gap_exp >= 0) chk("line_gap", 64'(gap), 64'(gap_exp));
        armed = 1'b0;
        if (ifc.byte_ready) begin
          cur = $sformatf("%s%c", cur, ifc.byte_data);
          chk("last_iff_newline", 64'(ifc.byte_last), 64'(ifc.byte_data == 8'h0A));
          if (ifc.byte_last) begin
            if (exp_q.size() == 0) chks("line_unexpected", cur, "<none>");
            else                   chks("line_text", cur, exp_q.pop_front());
            last_line = cur;
            cur = "";
            done++;
            lines_exp++;
            gap = 0;
            armed = 1'b1;
          end
        end
      end else if (armed) begin
        gap++;
      end
      stall_prev = ifc.byte_valid && !ifc.byte_ready;
      pd = ifc.byte_data;
      pl = ifc.byte_last;
      acc_prev = (acc_ch >= 0);
      @(posedge clk);
      #1;
      if (acc_ch >= 0) begin
        case (mode)
          0: val_m[acc_ch] = 1'b0;
          2: begin
            id_m[acc_ch] = 16'($urandom);
            st_m[acc_ch] = {$urandom, $urandom};
            en_m[acc_ch] = {$urandom, $urandom};
            de_m[acc_ch] = {$urandom, $urandom};
            sel_m = 3'(32'd1 << $urandom_range(0, 3));
          end
          default: ;
        endcase
      end
    end
    chk("lines_completed", 64'(done), 64'(nlines));
    chk("lines_sent", 64'(lines_sent), 64'(lines_exp));
  endtask

  initial begin
    int hs;
    for (int c = 0; c < 4; c++) begin
      id_m[c] = 16'h0000; st_m[c] = 64'd0; en_m[c] = 64'd0; de_m[c] = 64'd0;
    end
    last_line = "";
    do_reset();

    // full line from channel 2 with every field selected
    id_m[2] = 16'h00AB; st_m[2] = 64'h10; en_m[2] = 64'h25; de_m[2] = 64'h15;
    sel_m = 3'b111; val_m = 4'b0100;
    run(1, 1'b0, 0, -1);
    chks("line_all_fields", last_line, "2,00AB,0000000000000010,0000000000000025,0000000000000015\n");
    chk("len_all_fields", 64'(last_line.len()), 64'd58);
    chk("lines_sent_one", 64'(lines_sent), 64'd1);

    // minimal line, then delta only
    id_m[0] = 16'hBEEF; sel_m = 3'b000; val_m = 4'b0001;
    run(1, 1'b0, 0, -1);
    chks("line_id_only", last_line, "0,BEEF\n");
    chk("len_id_only", 64'(last_line.len()), 64'd7);
    de_m[0] = 64'hF; sel_m = 3'b100; val_m = 4'b0001;
    run(1, 1'b0, 0, -1);
    chks("line_delta_only", last_line, "0,BEEF,000000000000000F\n");
    chk("len_delta_only", 64'(last_line.len()), 64'd24);

    // all channels continuously valid from reset: grants rotate 0,1,2,3,0,...
    do_reset();
    for (int c = 0; c < 4; c++) begin
      id_m[c] = 16'h1000 + 16'(c); st_m[c] = 64'(c);
    end
    sel_m = 3'b001; val_m = 4'b1111;
    run(8, 1'b0, 1, -1);
    chks("rr_eighth_line", last_line, "3,1003,0000000000000003\n");

    // back-to-back ch1 events: exactly one idle cycle between lines
    id_m[1] = 16'h0001; sel_m = 3'b000; val_m = 4'b0010;
    run(2, 1'b0, 1, 1);
    chks("b2b_line", last_line, "1,0001\n");

    // random backpressure with fresh random events on every accept
    val_m = 4'b1111;
    run(1000, 1'b1, 2, -1);

    // reset in the middle of a line
    val_m = 4'b1111; sel_m = 3'b111; hs = 0;
    for (int k = 0; k < 300 && hs < 10; k++) begin
      drive();
      ifc.byte_ready = 1'b1;
      #1;
      if (ifc.byte_valid) hs++;
      @(posedge clk);
      #1;
    end
    chk("pre_reset_bytes", 64'(hs), 64'd10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_byte_valid", 64'(ifc.byte_valid), 64'd0);
    chk("mid_rst_byte_last", 64'(ifc.byte_last), 64'd0);
    chk("mid_rst_lines_sent", 64'(lines_sent), 64'd0);
    rst = 1'b0;
    rr_m = 0; lines_exp = 32'd0; exp_q.delete();
    drive();
    #1;
    chk("post_rst_grant_ch0", 64'(ifc.ev_ready), 64'd1);
    run(1, 1'b0, 1, -1);
    chk("post_rst_line_ch0", 64'(last_line.substr(0, 0) == "0"), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
